// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// sequencer states and the default memory depth.
package dmem_pkg;

  localparam int MEM_DEPTH_DEF = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALF2  = 2'd2,
    ST_DONE   = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_extract.sv
// Picks the addressed byte/half/word out of a memory word and
// sign- or zero-extends it to a 32-bit load result.
module dmem_lane_extract
  import dmem_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // right-align the addressed lane, then extend according to size
  always_comb begin
    shifted_s = mem_rd >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{sext & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: result = {{16{sext & shifted_s[15]}}, shifted_s[15:0]};
      SZ_WORD: result = mem_rd;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port arbiter and access sequencer for the single-ported data memory.
// Halfword stores go out as two one-hot byte writes.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  size0,
  input  logic        sext0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  size1,
  input  logic        sext1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] HALF2  = ST_HALF2;
  localparam logic [1:0] DONE   = ST_DONE;

  logic [1:0]  state_r, next_state_s;
  logic        last_grant_r, owner_r, we_r, sext_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic        ack0_r, ack1_r, err_r;
  logic        grant_valid_s, grant_s, size_err_s, range_err_s, err_s;
  logic [1:0]  lane_s;
  logic [31:0] load_s;

  assign lane_s = addr_r[1:0];

  // alignment / illegal-size / out-of-range check on the latched request
  always_comb begin
    case (size_r)
      SZ_BYTE: size_err_s = 1'b0;
      SZ_HALF: size_err_s = addr_r[0];
      SZ_WORD: size_err_s = (addr_r[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
    range_err_s = ({2'b00, addr_r[31:2]} >= 32'(MEM_DEPTH));
    err_s       = size_err_s | range_err_s;
  end

  // arbitration: round-robin against last_grant, or port 0 fixed priority
  always_comb begin
    grant_valid_s = req0 | req1;
    if (req0 && req1) begin
      grant_s = (PRIO_MODE == 1) ? 1'b0 : ~last_grant_r;
    end else if (req0) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  // sequencer next-state
  always_comb begin
    case (state_r)
      IDLE: begin
        if (grant_valid_s) next_state_s = ACCESS;
        else               next_state_s = IDLE;
      end
      ACCESS: begin
        if (we_r && !err_s && (size_r == SZ_HALF)) next_state_s = HALF2;
        else                                       next_state_s = DONE;
      end
      HALF2:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // memory interface decode from state and latched request only
  always_comb begin
    mem_we = 1'b0;
    mem_be = 4'b0000;
    mem_a  = 32'h0000_0000;
    mem_wd = 32'h0000_0000;
    case (state_r)
      ACCESS: begin
        mem_a  = {2'b00, addr_r[31:2]};
        mem_we = we_r & ~err_s;
        if (size_r == SZ_WORD) begin
          mem_be = 4'b1111;
          mem_wd = wdata_r;
        end else begin
          mem_be = 4'b0001 << lane_s;
          mem_wd = {24'h00_0000, wdata_r[7:0]};
        end
      end
      HALF2: begin
        mem_a  = {2'b00, addr_r[31:2]};
        mem_we = 1'b1;
        mem_be = 4'b0001 << ({1'b0, lane_s} + 3'd1);
        mem_wd = {24'h00_0000, wdata_r[15:8]};
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  dmem_lane_extract u_extract (
    .mem_rd (mem_rd),
    .lane   (lane_s),
    .size   (size_r),
    .sext   (sext_r),
    .result (load_s)
  );

  // state, request latch, load capture and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      size_r       <= SZ_BYTE;
      sext_r       <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && grant_valid_s) begin
        owner_r      <= grant_s;
        last_grant_r <= grant_s;
        we_r         <= grant_s ? we1    : we0;
        size_r       <= grant_s ? size1  : size0;
        sext_r       <= grant_s ? sext1  : sext0;
        addr_r       <= grant_s ? addr1  : addr0;
        wdata_r      <= grant_s ? wdata1 : wdata0;
      end
      if (state_r == ACCESS) begin
        rdata_r <= (we_r || err_s) ? 32'h0000_0000 : load_s;
      end
      ack0_r <= (next_state_s == DONE) && !owner_r;
      ack1_r <= (next_state_s == DONE) && owner_r;
      err_r  <= (next_state_s == DONE) ? err_s : 1'b0;
    end
  end

  assign ack0  = ack0_r;
  assign ack1  = ack1_r;
  assign err   = err_r;
  assign rdata = rdata_r;
  assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a round-robin instance with a byte-lane
// memory model, plus a fixed-priority instance for the arbitration check.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t fq[$];

  logic        rst_n;
  logic        req0, we0, sext0, req1, we1, sext1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err, busy, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_be;

  logic        f_req0, f_we0, f_sext0, f_req1, f_we1, f_sext1;
  logic [1:0]  f_size0, f_size1;
  logic [31:0] f_addr0, f_wdata0, f_addr1, f_wdata1;
  logic        f_ack0, f_ack1, f_err, f_busy, f_mem_we;
  logic [31:0] f_rdata, f_mem_a, f_mem_wd, f_mem_rd;
  logic [3:0]  f_mem_be;

  logic [31:0] mem [0:1023];

  dmem_access_ctrl #(.MEM_DEPTH(1024), .PRIO_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .size0(size0), .sext0(sext0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .size1(size1), .sext1(sext1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_access_ctrl #(.MEM_DEPTH(1024), .PRIO_MODE(1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .we0(f_we0), .size0(f_size0), .sext0(f_sext0), .addr0(f_addr0), .wdata0(f_wdata0),
    .req1(f_req1), .we1(f_we1), .size1(f_size1), .sext1(f_sext1), .addr1(f_addr1), .wdata1(f_wdata1),
    .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata), .err(f_err), .busy(f_busy),
    .mem_we(f_mem_we), .mem_be(f_mem_be), .mem_a(f_mem_a), .mem_wd(f_mem_wd), .mem_rd(f_mem_rd)
  );

  // memory model: one-hot BE writes wd[7:0] into that lane, any other BE writes the whole word
  assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && (mem_a < 32'd1024)) begin
      case (mem_be)
        4'b0001: mem[mem_a[9:0]][7:0]   <= mem_wd[7:0];
        4'b0010: mem[mem_a[9:0]][15:8]  <= mem_wd[7:0];
        4'b0100: mem[mem_a[9:0]][23:16] <= mem_wd[7:0];
        4'b1000: mem[mem_a[9:0]][31:24] <= mem_wd[7:0];
        default: mem[mem_a[9:0]]        <= mem_wd;
      endcase
    end
  end
  // the fixed-priority instance only performs loads from an all-zero memory
  assign f_mem_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_check(input string tag, input exp_t e, input logic a0, input logic a1,
                          input logic [31:0] rd, input logic er);
    chk({tag, "_ack_port"}, {30'b0, a1, a0}, e.port ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, rd, e.rdata);
    chk({tag, "_err"}, 32'(er), 32'(e.err));
    chk({tag, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // monitors: every ack pops one expectation
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (q.size() == 0) chk("rr_unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
      else sb_check("rr", q.pop_front(), ack0, ack1, rdata, err);
    end
  end
  always @(negedge clk) begin
    if (f_ack0 || f_ack1) begin
      if (fq.size() == 0) chk("fp_unexpected_ack", {30'b0, f_ack1, f_ack0}, 32'd0);
      else sb_check("fp", fq.pop_front(), f_ack0, f_ack1, f_rdata, f_err);
    end
  end

  task automatic issue(input logic port, input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat, input bit push);
    if (port) begin
      req1 = 1'b1; we1 = we; size1 = size; sext1 = sext; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; size0 = size; sext0 = sext; addr0 = addr; wdata0 = wdata;
    end
    if (push) q.push_back(exp_t'{port, exp_rd, exp_err, cyc + lat});
  endtask

  task automatic wait_ack(input logic port);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) got = 1'b1;
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
    chk("ack_within_bound", 32'(got), 32'd1);
  endtask

  // one complete single-port transaction with scoreboard entry
  task automatic op(input logic port, input logic we, input logic [1:0] size, input logic sext,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rd, input logic exp_err, input int lat);
    @(negedge clk);
    issue(port, we, size, sext, addr, wdata, exp_rd, exp_err, lat, 1'b1);
    wait_ack(port);
  endtask

  initial begin
    int n_ack;
    int c;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    {req0, we0, sext0, req1, we1, sext1} = 6'b0;
    size0 = SZ_BYTE; size1 = SZ_BYTE;
    addr0 = 32'h0; wdata0 = 32'h0; addr1 = 32'h0; wdata1 = 32'h0;
    {f_req0, f_we0, f_sext0, f_req1, f_we1, f_sext1} = 6'b0;
    f_size0 = SZ_WORD; f_size1 = SZ_ILL;
    f_addr0 = 32'h0; f_wdata0 = 32'h0; f_addr1 = 32'h0; f_wdata1 = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err_busy", {30'b0, err, busy}, 32'd0);
    chk("rst_mem_we_be", {27'b0, mem_we, mem_be}, 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    // word store then word load
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_mem_be", 32'(mem_be), 32'hF);
    chk("t1_mem_a", mem_a, 32'd4);
    chk("t1_mem_wd", mem_wd, 32'hDEADBEEF);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_ack(1'b0);
    op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // half store as two byte writes, then signed and unsigned half loads
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0A, 32'h8001, 32'h0, 1'b0, 3, 1'b1);
    @(negedge clk);
    chk("t2_c1_we", 32'(mem_we), 32'd1);
    chk("t2_c1_a", mem_a, 32'd2);
    chk("t2_c1_be", 32'(mem_be), 32'b0100);
    chk("t2_c1_wd", 32'(mem_wd[7:0]), 32'h01);
    @(negedge clk);
    chk("t2_c2_we", 32'(mem_we), 32'd1);
    chk("t2_c2_be", 32'(mem_be), 32'b1000);
    chk("t2_c2_wd", 32'(mem_wd[7:0]), 32'h80);
    wait_ack(1'b0);
    op(1'b0, 1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0, 32'hFFFF8001, 1'b0, 2);
    op(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 32'h00008001, 1'b0, 2);

    // byte store into lane 3, byte loads
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hF0, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    chk("t3_be", 32'(mem_be), 32'b1000);
    chk("t3_wd", mem_wd, 32'h000000F0);
    wait_ack(1'b0);
    op(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFFF0, 1'b0, 2);
    op(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h000000F0, 1'b0, 2);
    op(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 2);
    op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hF0ADBEEF, 1'b0, 2);

    // errors: misaligned word store, out-of-range store, illegal size, misaligned half
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h6, 32'h12345678, 32'h0, 1'b1, 2, 1'b1);
    @(negedge clk);
    chk("t5_misalign_we", 32'(mem_we), 32'd0);
    wait_ack(1'b0);
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1, 2, 1'b1);
    @(negedge clk);
    chk("t5_range_we", 32'(mem_we), 32'd0);
    wait_ack(1'b0);
    op(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 2);
    op(1'b0, 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    op(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 2);

    // reset in the second half of a half store: lane 2 written, lane 3 kept
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0A, 32'h1234, 32'h0, 1'b0, 3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_half2_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    chk("t6_rst_be", 32'(mem_be), 32'd0);
    chk("t6_rst_busy_ack", {29'b0, busy, ack1, ack0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin with both ports held: 0,1,0,1; port 1 also checks word 2
    @(negedge clk);
    c = cyc;
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    q.push_back(exp_t'{1'b0, 32'hF0ADBEEF, 1'b0, c + 2});
    q.push_back(exp_t'{1'b1, 32'h80340000, 1'b0, c + 5});
    q.push_back(exp_t'{1'b0, 32'hF0ADBEEF, 1'b0, c + 8});
    q.push_back(exp_t'{1'b1, 32'h80340000, 1'b0, c + 11});
    n_ack = 0;
    for (int i = 0; i < 20 && n_ack < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) n_ack++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_ack_count", 32'(n_ack), 32'd4);

    // fixed priority: port 0 served three times, port 1 only after req0 drops
    @(negedge clk);
    c = cyc;
    f_req0 = 1'b1;
    f_req1 = 1'b1;
    fq.push_back(exp_t'{1'b0, 32'h0, 1'b0, c + 2});
    fq.push_back(exp_t'{1'b0, 32'h0, 1'b0, c + 5});
    fq.push_back(exp_t'{1'b0, 32'h0, 1'b0, c + 8});
    fq.push_back(exp_t'{1'b1, 32'h0, 1'b1, c + 11});
    n_ack = 0;
    for (int i = 0; i < 30 && n_ack < 4; i++) begin
      @(negedge clk);
      if (f_ack0 || f_ack1) n_ack++;
      if (n_ack == 3) f_req0 = 1'b0;
    end
    f_req0 = 1'b0;
    f_req1 = 1'b0;
    chk("fp_ack_count", 32'(n_ack), 32'd4);

    repeat (4) @(negedge clk);
    chk("rr_queue_drained", 32'(q.size()), 32'd0);
    chk("fp_queue_drained", 32'(fq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Two-port arbiter and access sequencer in front of the single-ported DataMemory. It accepts byte, halfword and word load/store requests from port 0 (CPU load/store unit) and port 1 (DMA/debug), and grants one request at a time. It converts byte addresses to word index plus byte lane and drives the memory's WE/BE/A/WD. Halfword stores are split into two single-byte writes, because the memory writes all four lanes for any BE other than a one-hot value.

Parameters:
MEM_DEPTH, 1024, number of valid word indices; a request with addr[31:2] >= MEM_DEPTH is an error.
PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 winning.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active-low
reqN  in  1  request from port N (N = 0, 1); held high until ackN
weN  in  1  1 = store, 0 = load
sizeN  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
sextN  in  1  sign-extend a byte or half load
addrN  in  32  byte address
wdataN  in  32  store data, right-aligned
ackN  out  1  one-cycle completion pulse to port N
rdata  out  32  load result, valid while ack0 or ack1 is high
err  out  1  error flag, valid while ack0 or ack1 is high
busy  out  1  high whenever state is not IDLE
mem_we  out  1  write enable to memory
mem_be  out  4  byte enable to memory
mem_a  out  32  word index to memory
mem_wd  out  32  write data to memory
mem_rd  in  32  combinational read data from memory

Behaviour:
- Reset: async on rst_n low; every output 0; state = IDLE; last_grant = 1, so port 0 wins first.
- FSM states: IDLE, ACCESS, HALF2, DONE.
- IDLE: sample req0 and req1.
  - One requester: grant it.
  - Both requesting, PRIO_MODE = 0: grant the port other than last_grant.
  - Both requesting, PRIO_MODE = 1: grant port 0.
  - On grant, latch owner, we, size, sext, addr and wdata; update last_grant; go to ACCESS.
- Requester inputs are never used after the grant edge; memory outputs decode only from state and latched registers.
- Error check, evaluated on the latched request: error if size = 11, or size = half with addr[0] = 1, or size = word with addr[1:0] != 0, or addr[31:2] >= MEM_DEPTH.
- ACCESS, common to all requests:
  - mem_a = {2'b00, addr[31:2]}; lane = addr[1:0].
  - mem_we = we AND not error.
- ACCESS, store data by size:
  - Byte store: mem_be = 1 << lane; mem_wd = {24'b0, wdata[7:0]}.
  - Half store: mem_be = 1 << lane; mem_wd[7:0] = wdata[7:0]; next state HALF2.
  - Word store: mem_be = 4'b1111; mem_wd = wdata.
- ACCESS, loads:
  - The edge ending ACCESS registers the lane-extracted mem_rd into rdata.
  - Word: rdata = mem_rd.
  - Half: rdata = mem_rd[8*lane +: 16], sign- or zero-extended.
  - Byte: rdata = mem_rd[8*lane +: 8], sign- or zero-extended.
  - Store or error: rdata = 0.
- ACCESS next state: HALF2 for a valid half store, otherwise DONE.
- HALF2: mem_we = 1; mem_be = 1 << (lane + 1); mem_wd[7:0] = wdata[15:8]; next state DONE.
- DONE: ack of the owner port = 1 for exactly one cycle; err = latched error; next state IDLE.
- Outside ACCESS and HALF2: mem_we = 0 and mem_be = 0.
- Latency, counted from the IDLE cycle in which req is sampled (C0):
  - Ack in C2 for all loads, byte stores, word stores and errors.
  - Ack in C3 for half stores.
- Handshake rules:
  - Request fields stay stable while req is high.
  - Keeping req high in the cycle after ack is a new request; back-to-back requests are therefore sampled in IDLE, one cycle after DONE.
  - A losing requester keeps req high and waits; it is never starved in round-robin mode.
- Reset mid-operation: outputs clear immediately. mem_we drops before the next edge, so a pending or second-half byte is not written. No ack is issued; the requester re-issues after reset.
- An error access performs no memory write and still acks, with err = 1 and rdata = 0.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - the FSM state enum
  - the default MEM_DEPTH
- Sub-module dmem_lane_extract: purely combinational mem_rd, lane, size, sext to 32-bit load result. It is instantiated once and unit-tested separately.

Test Plan:
1. Port 0 word store, addr 0x10, data 0xDEADBEEF, then word load.
   -> Store: mem_we = 1, mem_be = 1111, mem_a = 4 in C1; ack0 in C2.
   -> Load: rdata = 0xDEADBEEF with ack0 in C2.
2. Half store, addr 0x0A, data 0x8001.
   -> C1: mem_a = 2, mem_be = 0100, wd[7:0] = 0x01. C2: mem_be = 1000, wd[7:0] = 0x80. ack0 in C3.
   -> Signed half load: 0xFFFF8001. Unsigned half load: 0x00008001.
3. Byte store of 0xF0 at addr 0x13, then byte load with sext = 1.
   -> Store: mem_be = 1000.
   -> Signed load: rdata = 0xFFFFFFF0. Unsigned load: 0x000000F0.
4. req0 and req1 held high continuously for 4 transactions.
   -> PRIO_MODE = 0: acks alternate 0, 1, 0, 1.
   -> PRIO_MODE = 1: port 0 is acked every time; port 1 is acked only after req0 drops.
5. Word store at addr 0x6, then a store at addr 0x1000.
   -> No mem_we in either case; each acked in C2 with err = 1; memory unchanged.
6. rst_n pulsed low during HALF2 of a half store to addr 0x0A.
   -> mem_we = 0 immediately; lane 3 of word 2 unchanged; no ack; busy = 0; next request serves port 0 first.
